// File: rtl/prefetch_fifo_wr_arbiter.sv
// prefetch_fifo_wr_arbiter: round-robin packet arbiter feeding the prefetch FIFO write port
module prefetch_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic                          fifo_wr_vld,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_vld,
  output logic [IW-1:0]                 grant_id,
  output logic [31:0]                   beat_total
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d, last_ptr_q, last_ptr_d, sel;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]   beat_total_q, beat_total_d;
  logic [IW:0]   cand;
  logic          found, fire, rel;
  // pick the first requester after the last granted one, wrapping around
  always_comb begin
    sel = '0;
    found = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (IW+1)'(last_ptr_q) + (IW+1)'(k);
      cand = cand >= (IW+1)'(NUM_REQ) ? cand - (IW+1)'(NUM_REQ) : cand;
      if (!found && req_vld[cand[IW-1:0]]) begin
        found = 1'b1;
        sel = cand[IW-1:0];
      end
    end
  end
  assign fire         = state_q == XFER && fifo_wr_vld && req_vld[grant_id_q];
  assign rel          = fire && (req_last[grant_id_q] || beat_cnt_q == CW'(MAX_BURST - 1));
  assign req_rdy      = state_q == XFER && fifo_wr_vld ? NUM_REQ'(1) << grant_id_q : '0;
  assign fifo_wr_en   = fire;
  assign fifo_wr_data = fire ? req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_vld    = state_q == XFER;
  assign grant_id     = grant_id_q;
  assign beat_total   = beat_total_q;
  // grant on arbitration win, count beats, release on last beat or burst limit
  always_comb begin
    state_d = state_q;
    grant_id_d = grant_id_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = fire ? beat_cnt_q + 1'b1 : beat_cnt_q;
    beat_total_d = fire ? beat_total_q + 32'd1 : beat_total_q;
    if (state_q == IDLE && found) begin
      state_d = XFER;
      grant_id_d = sel;
      beat_cnt_d = '0;
    end
    if (rel) begin
      state_d = IDLE;
      last_ptr_d = grant_id_q;
    end
  end
  // state registers; pointer resets to the top so requester 0 wins first
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q <= IDLE;
      grant_id_q <= '0;
      last_ptr_q <= IW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      beat_total_q <= '0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      beat_total_q <= beat_total_d;
    end
  end
endmodule

// File: tb/tb_prefetch_fifo_wr_arbiter.sv
// tb_prefetch_fifo_wr_arbiter: directed checks of grant order, bursts, stalls and reset
module tb_prefetch_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic           wr_clk = 1'b0;
  logic           wr_rst = 1'b1;
  logic [N-1:0]   req_vld, req_last, req_rdy;
  logic [N*W-1:0] req_data;
  logic           fifo_wr_vld, fifo_wr_en, grant_vld;
  logic [W-1:0]   fifo_wr_data;
  logic [1:0]     grant_id;
  logic [31:0]    beat_total;
  int total = 0;
  int bad = 0;
  int n;
  bit [8:0] sm [N][64];
  int hd [N];
  int tl [N];
  bit hold [N];
  bit pg;
  logic [7:0] wq[$], eq[$];
  int gq[$], eg[$], gb[$], eb[$];

  prefetch_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(16)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .req_vld(req_vld), .req_last(req_last),
    .req_data(req_data), .req_rdy(req_rdy), .fifo_wr_vld(fifo_wr_vld),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_vld(grant_vld),
    .grant_id(grant_id), .beat_total(beat_total)
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      hold[i] = 1'b0;
    end
    wq.delete(); eq.delete(); gq.delete(); eg.delete(); gb.delete(); eb.delete();
    pg = 1'b0;
  endtask

  task automatic push(int i, int cnt, int base, bit single);
    for (int k = 0; k < cnt; k++) begin
      sm[i][tl[i]] = {single || k == cnt - 1, 8'(base + k)};
      tl[i]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld[i] = hd[i] != tl[i] && !hold[i];
      {req_last[i], req_data[i*W +: W]} = sm[i][hd[i]];
    end
  endtask

  task automatic obs();
    for (int i = 0; i < N; i++)
      if (req_vld[i] && req_rdy[i]) hd[i]++;
    if (grant_vld && !pg) begin
      gq.push_back(int'(grant_id));
      gb.push_back(0);
    end
    if (fifo_wr_en) begin
      wq.push_back(fifo_wr_data);
      if (gb.size() > 0) gb[gb.size()-1]++;
    end
    pg = grant_vld;
  endtask

  task automatic cyc();
    drive();
    @(negedge wr_clk);
    obs();
    @(posedge wr_clk);
    #1;
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++)
      if (hd[i] != tl[i]) return 1'b1;
    return grant_vld;
  endfunction

  task automatic drain();
    n = 0;
    while (busy() && n < 500) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(n < 500), 1);
  endtask

  task automatic do_reset();
    wr_rst = 1'b1;
    fifo_wr_vld = 1'b1;
    clr();
    cyc();
    wr_rst = 1'b0;
  endtask

  task automatic cmp_all(string t);
    chk({t, "_wr_count"}, wq.size(), eq.size());
    for (int j = 0; j < wq.size() && j < eq.size(); j++)
      chk($sformatf("%s_wr_data[%0d]", t, j), wq[j], eq[j]);
    chk({t, "_grant_count"}, gq.size(), eg.size());
    for (int j = 0; j < gq.size() && j < eg.size(); j++)
      chk($sformatf("%s_grant[%0d]", t, j), gq[j], eg[j]);
    for (int j = 0; j < gb.size() && j < eb.size(); j++)
      chk($sformatf("%s_grant_beats[%0d]", t, j), gb[j], eb[j]);
  endtask

  initial begin
    // reset state with all requesters already asking, then full round-robin
    wr_rst = 1'b1;
    fifo_wr_vld = 1'b1;
    clr();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        push(i, 3, i*64 + p*16, 1'b0);
        for (int k = 0; k < 3; k++) eq.push_back(8'(i*64 + p*16 + k));
        eg.push_back(i);
        eb.push_back(3);
      end
    drive();
    @(negedge wr_clk);
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_beat_total", beat_total, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b0;
    repeat (16) cyc();
    chk("t1_total_round1", beat_total, 12);
    chk("t1_wr_en_round1", wq.size(), 12);
    drain();
    chk("t1_total", beat_total, 24);
    cmp_all("t1");

    // long packet split by the burst limit
    do_reset();
    push(2, 40, 'h80, 1'b0);
    for (int k = 0; k < 40; k++) eq.push_back(8'('h80 + k));
    eg = '{2, 2, 2};
    eb = '{16, 16, 8};
    drain();
    chk("t2_cycles", n, 43);
    chk("t2_total", beat_total, 40);
    cmp_all("t2");

    // FIFO back-pressure mid-packet
    do_reset();
    push(0, 8, 'h10, 1'b0);
    for (int k = 0; k < 8; k++) eq.push_back(8'('h10 + k));
    eg = '{0};
    eb = '{8};
    repeat (4) cyc();
    fifo_wr_vld = 1'b0;
    repeat (5) begin
      drive();
      @(negedge wr_clk);
      chk("t3_stall_wr_en", fifo_wr_en, 0);
      chk("t3_stall_req_rdy", req_rdy, 0);
      chk("t3_stall_grant_id", grant_id, 0);
      chk("t3_stall_grant_vld", grant_vld, 1);
      obs();
      @(posedge wr_clk);
      #1;
    end
    fifo_wr_vld = 1'b1;
    drive();
    @(negedge wr_clk);
    chk("t3_resume_wr_en", fifo_wr_en, 1);
    chk("t3_resume_data", fifo_wr_data, 'h13);
    obs();
    @(posedge wr_clk);
    #1;
    drain();
    chk("t3_total", beat_total, 8);
    cmp_all("t3");

    // granted requester goes quiet while another waits
    do_reset();
    push(1, 6, 'h20, 1'b0);
    push(3, 2, 'h30, 1'b0);
    for (int k = 0; k < 6; k++) eq.push_back(8'('h20 + k));
    eq.push_back(8'h30);
    eq.push_back(8'h31);
    eg = '{1, 3};
    eb = '{6, 2};
    repeat (3) cyc();
    hold[1] = 1'b1;
    repeat (3) begin
      drive();
      @(negedge wr_clk);
      chk("t4_hold_grant_id", grant_id, 1);
      chk("t4_hold_wr_en", fifo_wr_en, 0);
      chk("t4_hold_req_rdy", req_rdy, 4'b0010);
      obs();
      @(posedge wr_clk);
      #1;
    end
    hold[1] = 1'b0;
    drain();
    cmp_all("t4");

    // asynchronous reset on beat 2 of 5
    do_reset();
    push(2, 5, 'h40, 1'b0);
    repeat (2) cyc();
    drive();
    @(negedge wr_clk);
    chk("t5_pre_wr_en", fifo_wr_en, 1);
    chk("t5_pre_data", fifo_wr_data, 'h41);
    #1;
    wr_rst = 1'b1;
    #1;
    chk("t5_rst_grant_vld", grant_vld, 0);
    chk("t5_rst_wr_en", fifo_wr_en, 0);
    chk("t5_rst_req_rdy", req_rdy, 0);
    chk("t5_rst_beat_total", beat_total, 0);
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b0;
    clr();
    push(0, 1, 'h50, 1'b0);
    push(2, 1, 'h60, 1'b0);
    eq = '{8'h50, 8'h60};
    eg = '{0, 2};
    drain();
    chk("t5_total", beat_total, 2);
    cmp_all("t5");

    // single-beat packets alternate with an idle bubble each
    do_reset();
    push(1, 3, 'h70, 1'b1);
    push(3, 3, 'h78, 1'b1);
    eq = '{8'h70, 8'h78, 8'h71, 8'h79, 8'h72, 8'h7a};
    eg = '{1, 3, 1, 3, 1, 3};
    eb = '{1, 1, 1, 1, 1, 1};
    drain();
    chk("t6_cycles", n, 12);
    cmp_all("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prefetch_fifo_wr_arbiter.md
Name: prefetch_fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the prefetch FIFO among NUM_REQ packet-oriented requesters.
- Grants one requester at a time and holds the grant until that requester's packet ends or a burst limit is reached.
- Forwards the granted stream onto the FIFO write port, throttled by the FIFO's write-ready.
- Sits in the write clock domain, directly in front of the FIFO wr_en/wr_data/wr_vld interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, beat width; equals FIFO write data width
- MAX_BURST, 16, maximum beats per grant before forced release (1..256)

Ports:
- wr_clk  in  1  write-domain clock
- wr_rst  in  1  asynchronous active-high reset
- req_vld  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet, qualified by req_vld
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_rdy  out  NUM_REQ  per-requester beat accepted this cycle
- fifo_wr_vld  in  1  FIFO can accept a write this cycle
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- grant_vld  out  1  a requester currently holds the grant
- grant_id  out  clog2(NUM_REQ)  index of granted requester, meaningful when grant_vld=1
- beat_total  out  32  free-running count of beats written to FIFO, wraps at 2^32

Behaviour:
- Reset (wr_rst=1, asynchronous): state IDLE; grant_vld=0, grant_id=0; beat counter=0; beat_total=0; last-grant pointer=NUM_REQ-1, so requester 0 has first priority. All combinational outputs follow: req_rdy=0, fifo_wr_en=0, fifo_wr_data=0. Reset mid-packet abandons the packet; no partial-packet state survives.
- FSM states: IDLE, XFER.
- IDLE:
  - If any req_vld is set, select the first set bit searching from (last_ptr+1) mod NUM_REQ upward with wrap.
  - Register grant_id, set grant_vld=1, clear the beat counter, go to XFER.
  - Arbitration latency is 1 cycle: no beat transfers in IDLE.
- XFER:
  - req_rdy[grant_id] = fifo_wr_vld; all other req_rdy bits are 0.
  - A beat transfers when req_vld[g] & req_rdy[g] (g = grant_id). On a transfer: fifo_wr_en=1, fifo_wr_data = req_data slice g, beat counter +1, beat_total +1.
  - fifo_wr_en=0 and fifo_wr_data=0 whenever no beat transfers.
  - These paths are combinational (same cycle as the inputs).
- Release: on a transferred beat with req_last[g]=1, or on a transferred beat that brings the beat counter to MAX_BURST.
  - Next cycle: state IDLE, grant_vld=0, last_ptr=g.
  - Last and limit in the same beat cause a single release.
  - A packet cut at MAX_BURST continues only after the requester re-wins arbitration. Its later beats are not reordered with its own earlier beats.
- Stall: req_vld[g]=0 or fifo_wr_vld=0 holds XFER with no transfer and no timeout; grant_id is stable.
- Non-granted requesters see req_rdy=0 and must hold their data and req_vld.
- Fairness: with every requester continuously requesting, grants rotate 0,1,2,...,NUM_REQ-1,0. Each requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles plus FIFO stall cycles.
- A lone requester is re-granted after one IDLE bubble cycle.
- req_last with req_vld=0 is ignored.
- grant_id changes only on the IDLE->XFER transition.

Test Plan:
- Reset, then req_vld=4'b1111, all packets 3 beats, fifo_wr_vld=1 -> grant order 0,1,2,3,0; fifo_wr_en asserted 3 of every 4 cycles; beat_total=12 after the first round.
- Requester 2 alone sends a 40-beat packet, MAX_BURST=16 -> grants of 16,16,8 beats, one idle cycle between grants; fifo_wr_data sequence identical to the source; beat_total=40.
- fifo_wr_vld held low 5 cycles mid-packet -> fifo_wr_en=0, req_rdy=0, grant_id unchanged; transfer resumes the cycle fifo_wr_vld returns high with no lost or duplicated beat.
- Requester 1 drops req_vld mid-packet for 3 cycles while requester 3 requests -> grant stays on 1; requester 3 is granted only after requester 1's last beat.
- Assert wr_rst during XFER on beat 2 of 5 -> grant_vld, fifo_wr_en, req_rdy and beat_total go to 0 immediately; after release, requester 0 wins if requesting.
- Single-beat packets (req_last=1 on every beat) from requesters 1 and 3 -> alternating grants 1,3,1,3; each transfer is followed by an IDLE cycle.
